mcb_port_responder: RTL and testbench

Synthesizable stand-in for one Spartan-6 MIG user port (p0): accepts commands, write data and read requests on the same cmd/wr/rd FIFO signals the DDR3 controller exposes, and services them from an on-chip block RAM. It sits where the MIG core normally sits, opposite `ddruser`, so the user write/read engines can be exercised in simulation or on a board without DDR3 calibration.

---
 rtl/mcb_resp_pkg.sv | 40 ++++
 rtl/mcb_resp_fifo.sv | 91 +++++++++
 rtl/mcb_port_responder.sv | 365 ++++++++++++++++++++++++++++++++++++
 tb/tb_mcb_port_responder.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcb_resp_pkg.sv
// mcb_resp_pkg
// Shared definitions for the MIG user-port responder: instruction codes,
// engine state encoding and the command record carried through the
// command FIFO, plus small instruction-decode helpers.
// Build option (read by mcb_port_responder): MCB_RESP_ERR_INJECT_EN.
package mcb_resp_pkg;

  // MIG command instruction codes (cmd_instr)
  localparam logic [2:0] INSTR_WR      = 3'b000;
  localparam logic [2:0] INSTR_RD      = 3'b001;
  localparam logic [2:0] INSTR_WR_AP   = 3'b010;
  localparam logic [2:0] INSTR_RD_AP   = 3'b011;
  localparam logic [2:0] INSTR_REFRESH = 3'b100;

  // Widest word address the record can carry (30-bit byte address >> 4)
  localparam int WADDR_MAX = 26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2
  } eng_state_t;

  typedef struct packed {
    logic [2:0]           instr;
    logic [5:0]           bl;     // beats - 1
    logic [WADDR_MAX-1:0] waddr;  // word address, upper bits unused
  } cmd_rec_t;

  // Any instruction with bit 2 set is a refresh (no data movement)
  function automatic logic instr_is_refresh(input logic [2:0] instr);
    return instr[2];
  endfunction

  // Reads are 001/011; writes are 000/010
  function automatic logic instr_is_read(input logic [2:0] instr);
    return (!instr[2]) && instr[0];
  endfunction

endpackage

// File: rtl/mcb_resp_fifo.sv
// mcb_resp_fifo
// Synchronous first-word-fall-through FIFO. The head entry is presented on
// head_data whenever empty is low; pop removes it. Pushes while full and pops
// while empty are ignored. count/full/empty are registered.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (flushes)
//   push, push_data     write side
//   pop, head_data      read side (FWFT, head_data is 0 while empty)
//   count, full, empty  occupancy status
module mcb_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && !empty_r;

  // Next occupancy; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array, not reset (contents are don't-care while empty)
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and registered status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_W'(DEPTH));
      empty_r <= (count_nxt_s == CNT_W'(0));
    end
  end

  // FWFT head: forced to zero while empty so nothing stale is visible
  always_comb begin
    if (empty_r) begin
      head_data = '0;
    end else begin
      head_data = mem_r[rd_ptr_r];
    end
  end

  assign count = count_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/mcb_port_responder.sv
// mcb_port_responder
// Block-RAM stand-in for one Spartan-6 MIG user port (p0). Accepts commands,
// write data and read requests on the MIG cmd/wr/rd FIFO handshake and serves
// them from on-chip RAM after a fake calibration delay.
// Ports:
//   clk, rst_n                  single clock, synchronous active-low reset
//   calib_done                  port usable
//   cmd_*                       command FIFO push side and status
//   wr_*                        write data FIFO push side, status, underrun/error
//   rd_*                        read data FIFO (FWFT) pop side, status, overflow/error
// Build option: MCB_RESP_ERR_INJECT_EN -- read beats at INJECT_WORD_ADDR
// return data with bit 0 inverted (RAM itself is untouched).
module mcb_port_responder
  import mcb_resp_pkg::*;
#(
  parameter int DATA_WIDTH       = 128,
  parameter int MASK_SIZE        = 16,
  parameter int MEM_WORDS_LOG2   = 10,
  parameter int CMD_DEPTH        = 4,
  parameter int FIFO_DEPTH       = 64,
  parameter int CALIB_CYCLES     = 1000,
  parameter int ACCESS_LAT       = 8,
  parameter int INJECT_WORD_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  calib_done,
  input  logic                  cmd_en,
  input  logic [2:0]            cmd_instr,
  input  logic [5:0]            cmd_bl,
  input  logic [29:0]           cmd_byte_addr,
  output logic                  cmd_empty,
  output logic                  cmd_full,
  input  logic                  wr_en,
  input  logic [MASK_SIZE-1:0]  wr_mask,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  wr_empty,
  output logic [6:0]            wr_count,
  output logic                  wr_underrun,
  output logic                  wr_error,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_full,
  output logic                  rd_empty,
  output logic [6:0]            rd_count,
  output logic                  rd_overflow,
  output logic                  rd_error
);

  localparam int MW       = MEM_WORDS_LOG2;
  localparam int CAL_W    = $clog2(CALIB_CYCLES + 1);
  localparam int WCNT_W   = $clog2(ACCESS_LAT + 1);
  localparam int CMD_W    = $bits(cmd_rec_t);
  localparam int CMD_CW   = $clog2(CMD_DEPTH + 1);
  localparam int FIFO_CW  = $clog2(FIFO_DEPTH + 1);
  localparam int WRF_W    = MASK_SIZE + DATA_WIDTH;

  // ---------------------------------------------------------------- calibration
  logic [CAL_W-1:0] calib_cnt_r;
  logic             calib_done_r;
  logic             port_open_r;   // calib_done delayed one cycle; gates pushes

  // Calibration counter: calib_done rises on the CALIB_CYCLES-th edge after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      calib_cnt_r  <= '0;
      calib_done_r <= 1'b0;
      port_open_r  <= 1'b0;
    end else begin
      port_open_r <= calib_done_r;
      if (!calib_done_r) begin
        if (calib_cnt_r == CAL_W'(CALIB_CYCLES - 1)) begin
          calib_done_r <= 1'b1;
        end else begin
          calib_cnt_r <= calib_cnt_r + CAL_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------- command FIFO
  cmd_rec_t           cmd_in_s;
  cmd_rec_t           cmd_head_s;
  logic [CMD_W-1:0]   cmd_head_bits_s;
  logic [CMD_CW-1:0]  cmd_cnt_s;
  logic               cmd_fifo_full_s;
  logic               cmd_fifo_empty_s;
  logic               cmd_push_s;
  logic               cmd_pop_s;

  always_comb begin
    cmd_in_s       = '0;
    cmd_in_s.instr = cmd_instr;
    cmd_in_s.bl    = cmd_bl;
    cmd_in_s.waddr = WADDR_MAX'(cmd_byte_addr[MW+3:4]);
  end

  assign cmd_push_s = cmd_en && port_open_r && !cmd_fifo_full_s;
  assign cmd_head_s = cmd_rec_t'(cmd_head_bits_s);

  mcb_resp_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_push_s),
    .push_data (cmd_in_s),
    .pop       (cmd_pop_s),
    .head_data (cmd_head_bits_s),
    .count     (cmd_cnt_s),
    .full      (cmd_fifo_full_s),
    .empty     (cmd_fifo_empty_s)
  );

  // ---------------------------------------------------------------- write FIFO
  logic [WRF_W-1:0]      wr_head_s;
  logic [FIFO_CW-1:0]    wr_cnt_s;
  logic                  wr_fifo_full_s;
  logic                  wr_fifo_empty_s;
  logic                  wr_push_s;
  logic                  wr_pop_s;

  assign wr_push_s = wr_en && port_open_r && !wr_fifo_full_s;

  mcb_resp_fifo #(.WIDTH(WRF_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_push_s),
    .push_data ({wr_mask, wr_data}),
    .pop       (wr_pop_s),
    .head_data (wr_head_s),
    .count     (wr_cnt_s),
    .full      (wr_fifo_full_s),
    .empty     (wr_fifo_empty_s)
  );

  // ---------------------------------------------------------------- engine FSM
  eng_state_t        state_r;
  eng_state_t        state_n;
  eng_state_t        dispatch_state_s;
  logic [WCNT_W-1:0] wait_cnt_r;
  logic [5:0]        beat_cnt_r;
  logic [MW-1:0]     addr_r;
  logic              is_rd_r;
  logic              is_ref_r;
  logic              load_s;
  logic              beat_s;

  // State entered on dispatch. Latency is counted from the dispatch edge to the
  // first beat edge, so a data command waits ACCESS_LAT-1 cycles and then does
  // its first beat in the next cycle; with ACCESS_LAT==1 it skips WAIT.
  always_comb begin
    if (instr_is_refresh(cmd_head_s.instr) || (ACCESS_LAT > 1)) begin
      dispatch_state_s = ST_WAIT;
    end else begin
      dispatch_state_s = ST_XFER;
    end
  end

  // Next-state logic; a new command may be dispatched on the last beat
  always_comb begin
    state_n   = state_r;
    cmd_pop_s = 1'b0;
    load_s    = 1'b0;
    beat_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!cmd_fifo_empty_s) begin
          cmd_pop_s = 1'b1;
          load_s    = 1'b1;
          state_n   = dispatch_state_s;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == WCNT_W'(1)) begin
          state_n = is_ref_r ? ST_IDLE : ST_XFER;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_XFER: begin
        beat_s = 1'b1;
        if (beat_cnt_r == 6'd0) begin
          if (!cmd_fifo_empty_s) begin
            cmd_pop_s = 1'b1;
            load_s    = 1'b1;
            state_n   = dispatch_state_s;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          state_n = ST_XFER;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Engine state, wait/beat counters and running word address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= '0;
      beat_cnt_r <= 6'd0;
      addr_r     <= '0;
      is_rd_r    <= 1'b0;
      is_ref_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      if (load_s) begin
        // Refresh holds the engine the full ACCESS_LAT cycles
        wait_cnt_r <= instr_is_refresh(cmd_head_s.instr) ? WCNT_W'(ACCESS_LAT)
                                                         : WCNT_W'(ACCESS_LAT - 1);
        beat_cnt_r <= cmd_head_s.bl;
        addr_r     <= cmd_head_s.waddr[MW-1:0];
        is_rd_r    <= instr_is_read(cmd_head_s.instr);
        is_ref_r   <= instr_is_refresh(cmd_head_s.instr);
      end else begin
        if (state_r == ST_WAIT) begin
          wait_cnt_r <= wait_cnt_r - WCNT_W'(1);
        end
        if (beat_s) begin
          beat_cnt_r <= beat_cnt_r - 6'd1;
          addr_r     <= addr_r + MW'(1);   // wraps modulo RAM depth
        end
      end
    end
  end

  // ---------------------------------------------------------------- write beats
  logic [DATA_WIDTH-1:0] last_data_r;
  logic [MASK_SIZE-1:0]  last_mask_r;
  logic [DATA_WIDTH-1:0] beat_data_s;
  logic [MASK_SIZE-1:0]  beat_mask_s;
  logic                  wr_beat_s;
  logic                  wr_underrun_r;
  logic                  wr_error_r;

  assign wr_beat_s = beat_s && !is_rd_r;
  assign wr_pop_s  = wr_beat_s && !wr_fifo_empty_s;

  // On underrun the beat repeats the last popped word/mask
  always_comb begin
    if (wr_fifo_empty_s) begin
      beat_data_s = last_data_r;
      beat_mask_s = last_mask_r;
    end else begin
      beat_data_s = wr_head_s[DATA_WIDTH-1:0];
      beat_mask_s = wr_head_s[WRF_W-1:DATA_WIDTH];
    end
  end

  // Last-popped write word and underrun/error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_data_r   <= '0;
      last_mask_r   <= '0;
      wr_underrun_r <= 1'b0;
      wr_error_r    <= 1'b0;
    end else begin
      if (wr_pop_s) begin
        last_data_r <= beat_data_s;
        last_mask_r <= beat_mask_s;
      end
      wr_underrun_r <= wr_beat_s && wr_fifo_empty_s;
      if (wr_beat_s && wr_fifo_empty_s) begin
        wr_error_r <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- RAM
  logic [DATA_WIDTH-1:0] ram_r [2**MW];
  logic [DATA_WIDTH-1:0] ram_q_r;

  // Byte-masked write port and registered read port (contents survive reset)
  always_ff @(posedge clk) begin
    if (wr_beat_s) begin
      for (int b = 0; b < MASK_SIZE; b++) begin
        if (!beat_mask_s[b]) begin
          ram_r[addr_r][8*b +: 8] <= beat_data_s[8*b +: 8];
        end
      end
    end
    if (beat_s && is_rd_r) begin
      ram_q_r <= ram_r[addr_r];
    end
  end

  // ---------------------------------------------------------------- read path
  logic                  rd_pend_r;   // ram_q_r holds a beat to push this cycle
  logic [DATA_WIDTH-1:0] rd_push_data_s;
  logic [FIFO_CW-1:0]    rd_cnt_s;
  logic                  rd_fifo_full_s;
  logic                  rd_fifo_empty_s;
  logic                  rd_pop_s;
  logic                  rd_overflow_r;
  logic                  rd_error_r;

`ifdef MCB_RESP_ERR_INJECT_EN
  logic inj_r;

  // Remember whether the pending read beat came from the corrupted word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inj_r <= 1'b0;
    end else begin
      inj_r <= beat_s && is_rd_r && (addr_r == MW'(INJECT_WORD_ADDR));
    end
  end

  assign rd_push_data_s = ram_q_r ^ {{(DATA_WIDTH-1){1'b0}}, inj_r};
`else
  assign rd_push_data_s = ram_q_r;
`endif

  assign rd_pop_s = rd_en && calib_done_r;

  // Read pipeline valid and overflow/error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend_r     <= 1'b0;
      rd_overflow_r <= 1'b0;
      rd_error_r    <= 1'b0;
    end else begin
      rd_pend_r     <= beat_s && is_rd_r;
      rd_overflow_r <= rd_pend_r && rd_fifo_full_s;
      if (rd_pend_r && rd_fifo_full_s) begin
        rd_error_r <= 1'b1;
      end
    end
  end

  // The FIFO itself drops a push while full
  mcb_resp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend_r),
    .push_data (rd_push_data_s),
    .pop       (rd_pop_s),
    .head_data (rd_data),
    .count     (rd_cnt_s),
    .full      (rd_fifo_full_s),
    .empty     (rd_fifo_empty_s)
  );

  // ---------------------------------------------------------------- outputs
  assign calib_done  = calib_done_r;
  assign cmd_empty   = cmd_fifo_empty_s;
  assign cmd_full    = !port_open_r || cmd_fifo_full_s;
  assign wr_full     = !port_open_r || wr_fifo_full_s;
  assign wr_empty    = wr_fifo_empty_s;
  assign wr_count    = 7'(wr_cnt_s);
  assign wr_underrun = wr_underrun_r;
  assign wr_error    = wr_error_r;
  assign rd_full     = rd_fifo_full_s;
  assign rd_empty    = rd_fifo_empty_s;
  assign rd_count    = 7'(rd_cnt_s);
  assign rd_overflow = rd_overflow_r;
  assign rd_error    = rd_error_r;

endmodule

// File: tb/tb_mcb_port_responder.sv
// Directed self-checking bench for mcb_port_responder (default parameters).
module tb_mcb_port_responder;

  localparam int CALIB = 1000;
  localparam int LAT   = 8;
`ifdef MCB_RESP_ERR_INJECT_EN
  localparam logic [127:0] INJ = 128'd1;
`else
  localparam logic [127:0] INJ = 128'd0;
`endif
  localparam logic [2:0] WR  = 3'b000;
  localparam logic [2:0] RD  = 3'b001;
  localparam logic [2:0] REF = 3'b100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         calib_done;
  logic         cmd_en = 1'b0;
  logic [2:0]   cmd_instr = 3'd0;
  logic [5:0]   cmd_bl = 6'd0;
  logic [29:0]  cmd_byte_addr = 30'd0;
  logic         cmd_empty, cmd_full;
  logic         wr_en = 1'b0;
  logic [15:0]  wr_mask = 16'd0;
  logic [127:0] wr_data = 128'd0;
  logic         wr_full, wr_empty, wr_underrun, wr_error;
  logic [6:0]   wr_count;
  logic         rd_en = 1'b0;
  logic [127:0] rd_data;
  logic         rd_full, rd_empty, rd_overflow, rd_error;
  logic [6:0]   rd_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mcb_port_responder dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_empty(cmd_empty), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
    .wr_full(wr_full), .wr_empty(wr_empty), .wr_count(wr_count),
    .wr_underrun(wr_underrun), .wr_error(wr_error),
    .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full), .rd_empty(rd_empty),
    .rd_count(rd_count), .rd_overflow(rd_overflow), .rd_error(rd_error)
  );

  function automatic logic [127:0] tb_word(input int i);
    return {96'h0123_4567_89AB_CDEF_F00D_CAFE, 32'(i)};
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic push_wr(input logic [127:0] d, input logic [15:0] m);
    wr_en = 1'b1; wr_data = d; wr_mask = m;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic push_cmd(input logic [2:0] ins, input logic [5:0] bl, input logic [29:0] a);
    cmd_en = 1'b1; cmd_instr = ins; cmd_bl = bl; cmd_byte_addr = a;
    tick(1);
    cmd_en = 1'b0;
  endtask

  task automatic pop_rd();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  // bounded wait for calib_done; n = edges after release
  task automatic wait_calib(output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!calib_done && n < CALIB + 20);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    tick(3);
    total++;
    if ({calib_done, cmd_empty, cmd_full, wr_empty, wr_full, rd_empty, rd_full,
         wr_underrun, wr_error, rd_overflow, rd_error} !== 11'b0_1_1_1_1_1_0_0_0_0_0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=%b", {calib_done, cmd_empty, cmd_full, wr_empty,
               wr_full, rd_empty, rd_full, wr_underrun, wr_error, rd_overflow, rd_error},
               11'b0_1_1_1_1_1_0_0_0_0_0);
    end
    total++;
    if (wr_count !== 7'd0 || rd_count !== 7'd0 || rd_data !== 128'd0) begin
      bad++;
      $display("FAIL reset_counts got wr=%0d rd=%0d data=%h exp 0 0 0", wr_count, rd_count, rd_data);
    end
    rst_n = 1'b1;
    wait_calib(n);
    total++;
    if (n !== CALIB) begin
      bad++;
      $display("FAIL calib_latency got=%0d exp=%0d", n, CALIB);
    end
    total++;
    if (cmd_full !== 1'b1 || wr_full !== 1'b1) begin
      bad++;
      $display("FAIL full_at_calib got=%b%b exp=11", cmd_full, wr_full);
    end
    tick(1);
    total++;
    if (cmd_full !== 1'b0 || wr_full !== 1'b0) begin
      bad++;
      $display("FAIL full_after_calib got=%b%b exp=00", cmd_full, wr_full);
    end
  endtask

  task automatic test_write_read();
    for (int i = 1; i <= 4; i++) push_wr(tb_word(i), 16'h0000);
    total++;
    if (wr_count !== 7'd4) begin
      bad++;
      $display("FAIL wr_count_filled got=%0d exp=4", wr_count);
    end
    push_cmd(WR, 6'd3, 30'h100);
    tick(LAT);
    total++;
    if (wr_count !== 7'd4) begin
      bad++;
      $display("FAIL wr_pop_early got=%0d exp=4", wr_count);
    end
    tick(1);
    total++;
    if (wr_count !== 7'd3) begin
      bad++;
      $display("FAIL wr_pop_latency got=%0d exp=3", wr_count);
    end
    tick(10);
    total++;
    if (wr_empty !== 1'b1) begin
      bad++;
      $display("FAIL wr_drained got=%b exp=1", wr_empty);
    end
    push_cmd(RD, 6'd3, 30'h100);
    tick(LAT + 1);
    total++;
    if (rd_empty !== 1'b1) begin
      bad++;
      $display("FAIL rd_early got=%b exp=1", rd_empty);
    end
    tick(1);
    total++;
    if (rd_empty !== 1'b0 || rd_data !== tb_word(1)) begin
      bad++;
      $display("FAIL rd_first_word got empty=%b data=%h exp 0 %h", rd_empty, rd_data, tb_word(1));
    end
    tick(3);
    total++;
    if (rd_count !== 7'd4) begin
      bad++;
      $display("FAIL rd_count_peak got=%0d exp=4", rd_count);
    end
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (rd_data !== tb_word(i)) begin
        bad++;
        $display("FAIL rd_word_%0d got=%h exp=%h", i, rd_data, tb_word(i));
      end
      pop_rd();
    end
    total++;
    if (rd_empty !== 1'b1 || wr_error !== 1'b0 || rd_error !== 1'b0) begin
      bad++;
      $display("FAIL wr_rd_flags got empty=%b werr=%b rerr=%b exp 1 0 0", rd_empty, wr_error, rd_error);
    end
  endtask

  task automatic test_mask();
    logic [127:0] exp;
    push_wr({128{1'b1}}, 16'h0000);
    push_cmd(WR, 6'd0, 30'h0);
    tick(15);
    push_wr(128'h0102_0304_0506_0708_090A_0B0C_0D0E_0FAB, 16'hFFFE);
    push_cmd(WR, 6'd0, 30'h0);
    tick(15);
    push_cmd(RD, 6'd0, 30'h0);
    tick(12);
    exp = {{120{1'b1}}, 8'hAB} ^ INJ;
    total++;
    if (rd_empty !== 1'b0 || rd_data !== exp) begin
      bad++;
      $display("FAIL mask_merge got empty=%b data=%h exp=%h", rd_empty, rd_data, exp);
    end
    pop_rd();
  endtask

  task automatic test_underrun();
    int pulses = 0;
    push_wr(tb_word(11), 16'h0000);
    push_wr(tb_word(12), 16'h0000);
    push_cmd(WR, 6'd3, 30'h200);
    for (int k = 0; k < 25; k++) begin
      tick(1);
      if (wr_underrun === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 2 || wr_error !== 1'b1 || rd_error !== 1'b0) begin
      bad++;
      $display("FAIL underrun got pulses=%0d werr=%b rerr=%b exp 2 1 0", pulses, wr_error, rd_error);
    end
    push_cmd(RD, 6'd3, 30'h200);
    tick(14);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data !== ((i == 0) ? tb_word(11) : tb_word(12))) begin
        bad++;
        $display("FAIL underrun_word_%0d got=%h exp=%h", i, rd_data,
                 (i == 0) ? tb_word(11) : tb_word(12));
      end
      pop_rd();
    end
  endtask

  task automatic test_wr_full();
    for (int i = 0; i < 65; i++) push_wr(tb_word(100 + i), 16'h0000);
    total++;
    if (wr_count !== 7'd64 || wr_full !== 1'b1) begin
      bad++;
      $display("FAIL wr_full got count=%0d full=%b exp 64 1", wr_count, wr_full);
    end
    push_cmd(WR, 6'd63, 30'h400);
    tick(80);
    total++;
    if (wr_empty !== 1'b1 || wr_count !== 7'd0) begin
      bad++;
      $display("FAIL wr_full_drain got empty=%b count=%0d exp 1 0", wr_empty, wr_count);
    end
    push_cmd(RD, 6'd0, 30'h450);
    tick(12);
    total++;
    if (rd_data !== tb_word(105)) begin
      bad++;
      $display("FAIL burst_word_5 got=%h exp=%h", rd_data, tb_word(105));
    end
    pop_rd();
    push_cmd(RD, 6'd0, 30'h7F0);
    tick(12);
    total++;
    if (rd_data !== tb_word(163)) begin
      bad++;
      $display("FAIL burst_word_63 got=%h exp=%h", rd_data, tb_word(163));
    end
    pop_rd();
  endtask

  task automatic test_overflow();
    int pulses = 0;
    push_cmd(RD, 6'd63, 30'h0);
    push_cmd(RD, 6'd63, 30'h0);
    for (int k = 0; k < 200; k++) begin
      tick(1);
      if (rd_overflow === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 64 || rd_count !== 7'd64 || rd_full !== 1'b1 || rd_error !== 1'b1) begin
      bad++;
      $display("FAIL overflow got pulses=%0d count=%0d full=%b err=%b exp 64 64 1 1",
               pulses, rd_count, rd_full, rd_error);
    end
    total++;
    if (rd_data !== ({{120{1'b1}}, 8'hAB} ^ INJ)) begin
      bad++;
      $display("FAIL overflow_head got=%h exp=%h", rd_data, {{120{1'b1}}, 8'hAB} ^ INJ);
    end
    rd_en = 1'b1;
    tick(64);
    rd_en = 1'b0;
    total++;
    if (rd_empty !== 1'b1 || rd_count !== 7'd0) begin
      bad++;
      $display("FAIL overflow_drain got empty=%b count=%0d exp 1 0", rd_empty, rd_count);
    end
  endtask

  task automatic test_refresh();
    push_wr(tb_word(7), 16'h0000);
    push_cmd(REF, 6'd5, 30'h0);
    tick(20);
    total++;
    if (wr_count !== 7'd1 || cmd_empty !== 1'b1 || rd_empty !== 1'b1) begin
      bad++;
      $display("FAIL refresh got wcount=%0d cmd_empty=%b rd_empty=%b exp 1 1 1",
               wr_count, cmd_empty, rd_empty);
    end
    push_cmd(WR, 6'd0, 30'h300);
    tick(15);
    total++;
    if (wr_count !== 7'd0) begin
      bad++;
      $display("FAIL after_refresh got=%0d exp=0", wr_count);
    end
  endtask

  task automatic test_wrap();
    push_wr(tb_word(21), 16'h0000);
    push_wr(tb_word(22), 16'h0000);
    push_cmd(WR, 6'd1, 30'h3FF0);
    tick(15);
    push_cmd(RD, 6'd0, 30'h2000_3FF5);
    tick(12);
    total++;
    if (rd_data !== tb_word(21)) begin
      bad++;
      $display("FAIL wrap_top_word got=%h exp=%h", rd_data, tb_word(21));
    end
    pop_rd();
    push_cmd(RD, 6'd0, 30'h0);
    tick(12);
    total++;
    if (rd_data !== (tb_word(22) ^ INJ)) begin
      bad++;
      $display("FAIL wrap_word0 got=%h exp=%h", rd_data, tb_word(22) ^ INJ);
    end
    pop_rd();
  endtask

  task automatic test_reset_midop();
    int n;
    push_wr(tb_word(99), 16'h0000);
    push_cmd(WR, 6'd0, 30'h100);
    tick(3);
    rst_n = 1'b0;
    tick(2);
    total++;
    if (wr_count !== 7'd0 || wr_empty !== 1'b1 || cmd_empty !== 1'b1 ||
        calib_done !== 1'b0 || cmd_full !== 1'b1) begin
      bad++;
      $display("FAIL midop_reset got wc=%0d we=%b ce=%b cd=%b cf=%b exp 0 1 1 0 1",
               wr_count, wr_empty, cmd_empty, calib_done, cmd_full);
    end
    rst_n = 1'b1;
    wait_calib(n);
    total++;
    if (n !== CALIB) begin
      bad++;
      $display("FAIL recalib_latency got=%0d exp=%0d", n, CALIB);
    end
    tick(2);
    push_cmd(RD, 6'd0, 30'h100);
    tick(12);
    total++;
    if (rd_data !== tb_word(1)) begin
      bad++;
      $display("FAIL ram_retained got=%h exp=%h", rd_data, tb_word(1));
    end
    pop_rd();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_mask();
    test_underrun();
    test_wr_full();
    test_overflow();
    test_refresh();
    test_wrap();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
